// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared SRAM geometry constants and pipeline command type
package mem_pkg;

  localparam int SRAM_DW  = 256;
  localparam int SRAM_AW  = 19;
  localparam int BANK_MSB = 18;
  localparam int BANK_LSB = 15;
  localparam int LINE_MSB = 14;
  localparam int LINE_LSB = 5;

  localparam int BANK_W   = BANK_MSB - BANK_LSB + 1;

  // Wide enough for the largest supported client count (8).
  localparam int CLIENT_W = 3;

  // One accepted request as it travels down the two-stage pipe.
  typedef struct packed {
    logic [CLIENT_W-1:0] client;
    logic                write;
    logic                err;
    logic [SRAM_AW-1:0]  addr;
    logic [SRAM_DW-1:0]  wdata;
  } pipe_cmd_t;

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - round-robin grant with pointer that advances on accept
module rr_arb #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid
);

  localparam int IW = $clog2(N);

  // Index where the next search begins: one past the last granted client.
  logic [IW-1:0] ptr;

  // Search from ptr upward with wrap; first requester wins. Nothing is
  // granted while reset is held so req_ready stays low asynchronously.
  always_comb begin
    int            idx;
    logic [IW-1:0] sel;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    sel         = '0;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) begin
          idx = idx - N;
        end
        sel = IW'(idx);
        if (!grant_valid && req[sel]) begin
          grant[sel]  = 1'b1;
          grant_idx   = sel;
          grant_valid = 1'b1;
        end
      end
    end
  end

  // Pointer moves to the client after the winner, only when a grant happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_sram_arb.sv
// rtl/mem_sram_arb.sv - multi-client arbiter in front of one SRAM bank, fixed 2-cycle response
module mem_sram_arb
  import mem_pkg::*;
#(
  parameter int         NUM_CLIENTS = 4,
  parameter logic [3:0] BANK_ID     = 4'd0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CLIENTS-1:0]              req_valid,
  input  logic [NUM_CLIENTS-1:0]              req_write,
  input  logic [NUM_CLIENTS-1:0][SRAM_AW-1:0] req_addr,
  input  logic [NUM_CLIENTS-1:0][SRAM_DW-1:0] req_wdata,
  output logic [NUM_CLIENTS-1:0]              req_ready,
  output logic                                sram_cs,
  output logic                                sram_read,
  output logic                                sram_write,
  output logic [3:0]                          sram_id,
  output logic [SRAM_AW-1:0]                  sram_addr,
  output logic [SRAM_DW-1:0]                  sram_wdata,
  input  logic [SRAM_DW-1:0]                  sram_rdata,
  output logic                                rsp_valid,
  output logic [$clog2(NUM_CLIENTS)-1:0]      rsp_client,
  output logic                                rsp_write,
  output logic                                rsp_err,
  output logic [SRAM_DW-1:0]                  rsp_data
);

  localparam int CW = $clog2(NUM_CLIENTS);

  logic [NUM_CLIENTS-1:0] grant;
  logic [CW-1:0]          grant_idx;
  logic                   grant_valid;

  pipe_cmd_t cmd_in;
  pipe_cmd_t s1_cmd;
  logic      s1_valid;
  logic      s1_good;
  logic      s2_rd_good;

  rr_arb #(
    .N (NUM_CLIENTS)
  ) u_rr_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (req_valid),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // The pipe never stalls, so a grant is an accept.
  assign req_ready = grant;

  // Capture the winning client's request; write data is zeroed for reads so
  // it never leaks onto the SRAM bus.
  always_comb begin
    cmd_in = '0;
    if (grant_valid) begin
      cmd_in.client = CLIENT_W'(grant_idx);
      cmd_in.write  = req_write[grant_idx];
      cmd_in.err    = (req_addr[grant_idx][BANK_MSB:BANK_LSB] != BANK_ID);
      cmd_in.addr   = req_addr[grant_idx];
      cmd_in.wdata  = req_write[grant_idx] ? req_wdata[grant_idx] : '0;
    end
  end

  // Stage 1: register the accepted command; idle cycles load all zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cmd   <= '0;
    end else begin
      s1_valid <= grant_valid;
      s1_cmd   <= cmd_in;
    end
  end

  // Wrong-bank requests ride the pipe for their error response but never
  // touch the SRAM, so the bus looks idle for them.
  assign s1_good    = s1_valid & ~s1_cmd.err;
  assign sram_cs    = s1_good;
  assign sram_write = s1_good & s1_cmd.write;
  assign sram_read  = s1_good & ~s1_cmd.write;
  assign sram_addr  = s1_good ? s1_cmd.addr : '0;
  assign sram_wdata = (s1_good & s1_cmd.write) ? s1_cmd.wdata : '0;
  assign sram_id    = BANK_ID;

  // Stage 2: response attributes follow the command one cycle later, which
  // lines up with the SRAM returning read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_client <= '0;
      rsp_write  <= 1'b0;
      rsp_err    <= 1'b0;
      s2_rd_good <= 1'b0;
    end else begin
      rsp_valid  <= s1_valid;
      rsp_client <= CW'(s1_cmd.client);
      rsp_write  <= s1_cmd.write;
      rsp_err    <= s1_cmd.err;
      s2_rd_good <= sram_read;
    end
  end

  // Only a good read forwards SRAM data; writes and errors return zero.
  assign rsp_data = s2_rd_good ? sram_rdata : '0;

endmodule

// File: tb/tb_mem_sram_arb.sv
// tb/tb_mem_sram_arb.sv - directed self-checking bench for mem_sram_arb
module tb_mem_sram_arb;
  import mem_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N-1:0]              req_valid;
  logic [N-1:0]              req_write;
  logic [N-1:0][SRAM_AW-1:0] req_addr;
  logic [N-1:0][SRAM_DW-1:0] req_wdata;
  logic [N-1:0]              req_ready;
  logic                      sram_cs, sram_read, sram_write;
  logic [3:0]                sram_id;
  logic [SRAM_AW-1:0]        sram_addr;
  logic [SRAM_DW-1:0]        sram_wdata;
  logic [SRAM_DW-1:0]        sram_rdata;
  logic                      rsp_valid;
  logic [1:0]                rsp_client;
  logic                      rsp_write, rsp_err;
  logic [SRAM_DW-1:0]        rsp_data;

  int checks   = 0;
  int failures = 0;
  bit monitor_on = 1'b0;

  logic [SRAM_DW-1:0] mem [0:1023];
  logic [SRAM_DW-1:0] pat_a5;

  always #5 clk = ~clk;

  mem_sram_arb #(
    .NUM_CLIENTS (N),
    .BANK_ID     (4'd0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .sram_cs    (sram_cs),
    .sram_read  (sram_read),
    .sram_write (sram_write),
    .sram_id    (sram_id),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_client (rsp_client),
    .rsp_write  (rsp_write),
    .rsp_err    (rsp_err),
    .rsp_data   (rsp_data)
  );

  // Ordered SRAM: write and read commands take effect at the clock edge,
  // read data appears the following cycle.
  always @(posedge clk) begin
    if (sram_cs && sram_write) mem[sram_addr[LINE_MSB:LINE_LSB]] <= sram_wdata;
    if (sram_cs && sram_read)  sram_rdata <= mem[sram_addr[LINE_MSB:LINE_LSB]];
  end

  // Structural invariants sampled every falling edge outside reset.
  always @(negedge clk) begin
    if (monitor_on && !rst) begin
      checks++;
      if (sram_read && sram_write) begin
        failures++;
        $display("FAIL rw_exclusive got read=%0b write=%0b need not both 1", sram_read, sram_write);
      end
      checks++;
      if (!$onehot0(req_ready)) begin
        failures++;
        $display("FAIL ready_onehot0 got=%b need onehot0", req_ready);
      end
      checks++;
      if (sram_cs && sram_id !== 4'd0) begin
        failures++;
        $display("FAIL sram_id got=%0h need=0", sram_id);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_reqs();
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    req_write = 4'b0101;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b need=0000", req_ready); end
    checks++;
    if ({sram_cs, sram_read, sram_write} !== 3'b000) begin
      failures++; $display("FAIL reset_sram_ctl got=%b need=000", {sram_cs, sram_read, sram_write});
    end
    checks++;
    if (sram_addr !== '0 || sram_wdata !== '0) begin
      failures++; $display("FAIL reset_sram_bus got addr=%0h wdata=%0h need 0", sram_addr, sram_wdata);
    end
    checks++;
    if ({rsp_valid, rsp_client, rsp_write, rsp_err} !== 5'b0 || rsp_data !== '0) begin
      failures++; $display("FAIL reset_rsp got v=%0b c=%0d w=%0b e=%0b d=%0h need 0",
                           rsp_valid, rsp_client, rsp_write, rsp_err, rsp_data);
    end
    checks++;
    if (sram_id !== 4'd0) begin failures++; $display("FAIL reset_sram_id got=%0h need=0", sram_id); end
    do_reset();
  endtask

  task automatic test_write_read();
    do_reset();
    req_valid    = 4'b0001;
    req_write    = 4'b0001;
    req_addr[0]  = 19'h00040;
    req_wdata[0] = pat_a5;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL wr_ready got=%b need=0001", req_ready); end
    step();
    req_write = 4'b0000;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL rd_ready got=%b need=0001", req_ready); end
    checks++;
    if ({sram_cs, sram_read, sram_write} !== 3'b101) begin
      failures++; $display("FAIL wr_sram_ctl got=%b need=101", {sram_cs, sram_read, sram_write});
    end
    checks++;
    if (sram_addr !== 19'h00040 || sram_wdata !== pat_a5) begin
      failures++; $display("FAIL wr_sram_bus got addr=%0h wdata=%0h need addr=40 wdata=a5..", sram_addr, sram_wdata);
    end
    step();
    req_valid = 4'b0000;
    #1;
    checks++;
    if ({sram_cs, sram_read, sram_write} !== 3'b110 || sram_addr !== 19'h00040 || sram_wdata !== '0) begin
      failures++; $display("FAIL rd_sram got ctl=%b addr=%0h wdata=%0h need ctl=110 addr=40 wdata=0",
                           {sram_cs, sram_read, sram_write}, sram_addr, sram_wdata);
    end
    checks++;
    if ({rsp_valid, rsp_write, rsp_err} !== 3'b110 || rsp_client !== 2'd0 || rsp_data !== '0) begin
      failures++; $display("FAIL wr_rsp got v/w/e=%b c=%0d d=%0h need 110 c=0 d=0",
                           {rsp_valid, rsp_write, rsp_err}, rsp_client, rsp_data);
    end
    step();
    checks++;
    if ({rsp_valid, rsp_write, rsp_err} !== 3'b100 || rsp_client !== 2'd0 || rsp_data !== pat_a5) begin
      failures++; $display("FAIL rd_rsp got v/w/e=%b c=%0d d=%0h need 100 c=0 d=a5..",
                           {rsp_valid, rsp_write, rsp_err}, rsp_client, rsp_data);
    end
    checks++;
    if (sram_cs !== 1'b0) begin failures++; $display("FAIL rd_idle_cs got=%b need=0", sram_cs); end
    step();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0) begin
      failures++; $display("FAIL wr_rd_drain got v=%b d=%0h need v=0 d=0", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_ready;
    do_reset();
    for (int i = 0; i < N; i++) req_addr[i] = SRAM_AW'(i * 32);
    req_valid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) req_valid = 4'b0000;
      #1;
      exp_ready = (k < 8) ? (N'(1) << (k % 4)) : '0;
      checks++;
      if (req_ready !== exp_ready) begin
        failures++; $display("FAIL rr_ready[%0d] got=%b need=%b", k, req_ready, exp_ready);
      end
      checks++;
      if (k < 2) begin
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rr_rsp_early[%0d] got=%b need=0", k, rsp_valid); end
      end else if (rsp_valid !== 1'b1 || rsp_client !== 2'((k - 2) % 4)) begin
        failures++; $display("FAIL rr_rsp[%0d] got v=%b c=%0d need v=1 c=%0d", k, rsp_valid, rsp_client, (k - 2) % 4);
      end
      step();
    end
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rr_drain got=%b need=0", rsp_valid); end
  endtask

  task automatic test_bank_err();
    do_reset();
    req_valid   = 4'b0100;
    req_write   = 4'b0000;
    req_addr[2] = 19'h48000;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL err_ready got=%b need=0100", req_ready); end
    step();
    req_valid = 4'b0000;
    #1;
    checks++;
    if ({sram_cs, sram_read, sram_write} !== 3'b000 || sram_addr !== '0) begin
      failures++; $display("FAIL err_sram got ctl=%b addr=%0h need ctl=000 addr=0",
                           {sram_cs, sram_read, sram_write}, sram_addr);
    end
    step();
    checks++;
    if ({rsp_valid, rsp_write, rsp_err} !== 3'b101 || rsp_client !== 2'd2 || rsp_data !== '0) begin
      failures++; $display("FAIL err_rsp got v/w/e=%b c=%0d d=%0h need 101 c=2 d=0",
                           {rsp_valid, rsp_write, rsp_err}, rsp_client, rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_addr[0] = 19'h00000;
    req_addr[3] = 19'h00060;
    req_valid   = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin failures++; $display("FAIL b2b_ready[%0d] got=%b need=1000", k, req_ready); end
      step();
    end
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL b2b_wrap got=%b need=0001", req_ready); end
    step();
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin failures++; $display("FAIL b2b_next got=%b need=1000", req_ready); end
    step();
    req_valid = 4'b0000;
  endtask

  task automatic test_reset_inflight();
    do_reset();
    req_valid    = 4'b0001;
    req_write    = 4'b0001;
    req_addr[0]  = 19'h00080;
    req_wdata[0] = {8{32'h1234_5678}};
    #1;
    step();
    req_valid   = 4'b0010;
    req_write   = 4'b0000;
    req_addr[1] = 19'h000a0;
    #1;
    step();
    checks++;
    if (rsp_valid !== 1'b1 || sram_cs !== 1'b1) begin
      failures++; $display("FAIL inflight_pre got rsp_valid=%b sram_cs=%b need 1 1", rsp_valid, sram_cs);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== '0 || {sram_cs, sram_read, sram_write} !== 3'b000 || sram_addr !== '0 || sram_wdata !== '0) begin
      failures++; $display("FAIL inflight_sram got rdy=%b ctl=%b addr=%0h need all 0",
                           req_ready, {sram_cs, sram_read, sram_write}, sram_addr);
    end
    checks++;
    if ({rsp_valid, rsp_client, rsp_write, rsp_err} !== 5'b0 || rsp_data !== '0) begin
      failures++; $display("FAIL inflight_rsp got v=%b c=%0d w=%b e=%b need 0", rsp_valid, rsp_client, rsp_write, rsp_err);
    end
    req_valid = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 4'b1111;
    req_write = 4'b0000;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL post_rst_ptr got=%b need=0001", req_ready); end
    step();
    req_valid = 4'b0000;
    #1;
    checks++;
    if (sram_cs !== 1'b1 || sram_addr !== 19'h00080 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL post_rst_s1 got cs=%b addr=%0h rsp_valid=%b need cs=1 addr=80 rsp_valid=0",
                           sram_cs, sram_addr, rsp_valid);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_client !== 2'd0 || rsp_write !== 1'b0) begin
      failures++; $display("FAIL post_rst_rsp got v=%b c=%0d w=%b need v=1 c=0 w=0", rsp_valid, rsp_client, rsp_write);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL post_rst_drain got=%b need=0", rsp_valid); end
  endtask

  initial begin
    pat_a5     = {32{8'hA5}};
    sram_rdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = {8{32'h1000_0000 + 32'(i)}};
    clear_reqs();
    test_reset();
    monitor_on = 1'b1;
    test_write_read();
    test_round_robin();
    test_bank_err();
    test_back_to_back();
    test_reset_inflight();
    monitor_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_sram_arb.md
MEM_SRAM_ARB -- requirements
Module: mem_sram_arb

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 4, number of requesting clients (2..8).
REQ-002 SHALL have parameter BANK_ID, default 4'd0, the bank this block serves; compared against addr[18:15].
REQ-003 SHALL have port clk input 1: the single clock.
REQ-004 SHALL have port rst input 1: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid input NUM_CLIENTS: per-client request valid.
REQ-006 SHALL have port req_write input NUM_CLIENTS: 1=write, 0=read.
REQ-007 SHALL have port req_addr input NUM_CLIENTS x 19: byte address; [18:15] bank, [14:5] line.
REQ-008 SHALL have port req_wdata input NUM_CLIENTS x 256: write data.
REQ-009 SHALL have port req_ready output NUM_CLIENTS: per-client accept (one-hot or zero).
REQ-010 SHALL have ports sram_cs, sram_read and sram_write, each output 1: SRAM controls.
REQ-011 SHALL have port sram_id output 4: always BANK_ID.
REQ-012 SHALL have port sram_addr output 19: SRAM address.
REQ-013 SHALL have port sram_wdata output 256: SRAM write data.
REQ-014 SHALL have port sram_rdata input 256: SRAM read data, valid the cycle after a read command.
REQ-015 SHALL have port rsp_valid output 1: response valid, one cycle, no backpressure.
REQ-016 SHALL have port rsp_client output $clog2(NUM_CLIENTS): responding client index.
REQ-017 SHALL have port rsp_write output 1: response is a write acknowledge.
REQ-018 SHALL have port rsp_err output 1: request was rejected (bank mismatch).
REQ-019 SHALL have port rsp_data output 256: read data; 0 for writes and errors.

Function
REQ-020 Accept = req_valid[i] & req_ready[i]; at most one accept per cycle; req_ready[i] SHALL be asserted only when req_valid[i] is high and i is granted.
REQ-021 Arbitration SHALL be round-robin: the search starts at (last granted + 1) mod NUM_CLIENTS; the pointer starts at 0 after reset and advances only on accept.
REQ-022 When no stage is stalled, one request per cycle SHALL be accepted; the block never stalls internally.
REQ-023 Stage 1 (cycle T+1 after accept at T) SHALL register the command; for a matching bank it drives sram_cs=1, exactly one of sram_read/sram_write, sram_addr=req_addr, and sram_wdata=req_wdata (writes only, else 0).
REQ-024 When addr[18:15]!=BANK_ID, the block SHALL still accept the request but SHALL keep sram_cs=0 for it; the response carries rsp_err=1.
REQ-025 sram_read and sram_write SHALL never both be 1; when idle, sram_cs/read/write=0 and sram_addr/wdata=0.
REQ-026 Stage 2 (T+2) SHALL assert rsp_valid=1 with rsp_client, rsp_write and rsp_err as registered; rsp_data=sram_rdata for a good read, else 0.
REQ-027 Fixed latency SHALL be 2 cycles accept->rsp_valid for all request types; responses stay in accept order.
REQ-028 A write followed next cycle by a read of the same line SHALL return the new data, because the SRAM is ordered.
REQ-029 Back-to-back accepts from the same client SHALL be allowed only when no other client is valid.

Reset
REQ-030 While rst=1, asynchronously: req_ready=0, sram_cs/read/write=0, sram_addr=0, sram_wdata=0, rsp_valid=0, rsp_client=0, rsp_write=0, rsp_err=0, rsp_data=0, RR pointer=0.
REQ-031 Requests in flight when rst asserts SHALL be dropped with no response; the first accept is possible in the first cycle after rst deasserts.

Structure
REQ-032 Package mem_pkg SHALL hold SRAM_DW=256, SRAM_AW=19, BANK_MSB=18, BANK_LSB=15, LINE_MSB=14, LINE_LSB=5, and a typedef struct for the pipeline command (client, write, err, addr, wdata).
REQ-033 Sub-module rr_arb (parameter N) SHALL implement the round-robin grant and pointer; mem_sram_arb instantiates it once.

Verification
REQ-034 Single write then read: client0 writes addr 0x00040 data A5..A5 at T, reads at T+1 -> sram_write at T+1, sram_read at T+2, rsp_valid T+2 (write, client0), T+3 rsp_data=A5..A5.
REQ-035 All 4 clients valid continuously -> grants 0,1,2,3,0,1,2,3; one rsp_valid per cycle, rsp_client in the same order.
REQ-036 Client2 read, addr 0x48000 with BANK_ID=0 -> sram_cs stays 0; rsp_valid at T+2 with rsp_err=1, rsp_client=2, rsp_data=0.
REQ-037 Only client3 valid for 3 cycles -> accepted each cycle; pointer then favours client0 when clients 0 and 3 are both valid.
REQ-038 Assert rst while 2 requests are in flight -> all outputs 0 immediately, no rsp_valid after release, pointer=0.
REQ-039 Assertion checks: sram_read&sram_write never both 1; $onehot0(req_ready); sram_id==BANK_ID whenever sram_cs=1.
